// File: rtl/fnd_digit_scanner_if.sv
// Capture-request and scanned-digit bundle between the adder datapath, the digit scanner
// and the FND BCD-to-segment decoder.
interface fnd_digit_scanner_if;
  logic [13:0] i_Value;
  logic        i_Load;
  logic        o_Busy;
  logic [3:0]  o_Digit_Sel;
  logic [3:0]  o_Digit_Value;
  logic        o_Digit_EN;
  logic        o_Overflow;

  modport master (
    output i_Value, i_Load,
    input  o_Busy, o_Digit_Sel, o_Digit_Value, o_Digit_EN, o_Overflow
  );

  modport slave (
    input  i_Value, i_Load,
    output o_Busy, o_Digit_Sel, o_Digit_Value, o_Digit_EN, o_Overflow
  );
endinterface

// File: rtl/fnd_digit_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a free-running 4-digit
// time-multiplexed scanner with optional leading-zero blanking and an overflow glyph.
module fnd_digit_scanner #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  fnd_digit_scanner_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [3:0] OVF_GLYPH = 4'hA;

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state_q, state_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [15:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;

  logic [15:0]   bcd_adj;
  logic [15:0]   bcd_shift;
  logic [3:0]    digit_nib;
  logic          lead_zero;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
    end
  end

  // One double-dabble iteration: correct nibbles >= 5, then shift the next binary bit in.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[14:0], bin_q[13]};
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.i_Load) begin
          state_d    = CONV;
          bin_d      = bus.i_Value;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (bus.i_Value > 14'd9999);
        end
      end
      CONV: begin
        bcd_d = bcd_shift;
        bin_d = {bin_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        // The 14th iteration commits straight from the shifter so busy lasts exactly 14 cycles.
        if (cnt_q == 4'd13) begin
          state_d = IDLE;
          disp_d  = bcd_shift;
          ovf_d   = ovf_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  // lead_zero: the selected digit and every digit above it are zero.
  always_comb begin
    digit_nib = disp_q[3:0];
    lead_zero = 1'b0;
    case (idx_q)
      2'd1: begin
        digit_nib = disp_q[7:4];
        lead_zero = (disp_q[15:4] == 12'd0);
      end
      2'd2: begin
        digit_nib = disp_q[11:8];
        lead_zero = (disp_q[15:8] == 8'd0);
      end
      2'd3: begin
        digit_nib = disp_q[15:12];
        lead_zero = (disp_q[15:12] == 4'd0);
      end
      default: ;
    endcase
  end

  assign bus.o_Busy        = (state_q == CONV);
  assign bus.o_Overflow    = ovf_q;
  assign bus.o_Digit_Sel   = ~(4'b0001 << idx_q);
  assign bus.o_Digit_Value = ovf_q ? OVF_GLYPH : digit_nib;
  assign bus.o_Digit_EN    = BLANK_LZ && !ovf_q && lead_zero;

endmodule
